// File: rtl/friscv_issue_scoreboard.sv
// Single-entry issue stage with a central per-register pending-write scoreboard.
// Optional FRISCV_SCB_RETIRE_FWD_EN: same-cycle retires are subtracted before the hazard check.
module friscv_issue_scoreboard #(
    parameter int NB_UNIT    = 3,
    parameter int NB_INT_REG = 32,
    parameter int CNT_W      = 3,
    parameter int INST_BUS_W = 80
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [INST_BUS_W-1:0]   i_instbus,
    input  logic [NB_UNIT-1:0]      i_unit,
    input  logic [4:0]              i_rs1,
    input  logic [4:0]              i_rs2,
    input  logic [4:0]              i_rd,
    input  logic                    i_rd_wr,
    output logic [NB_UNIT-1:0]      o_valid,
    input  logic [NB_UNIT-1:0]      o_ready,
    output logic [INST_BUS_W-1:0]   o_instbus,
    input  logic [NB_UNIT-1:0]      ret_valid,
    input  logic [NB_UNIT*5-1:0]    ret_rd,
    output logic                    busy,
    output logic                    err_unit,
    output logic                    err_retire
);

    // Wide enough for a counter plus up to 8 same-cycle retires without wrapping.
    localparam int SUM_W = CNT_W + 4;

    logic                  full_reg;
    logic [INST_BUS_W-1:0] instbus_reg;
    logic [NB_UNIT-1:0]    unit_reg;
    logic [4:0]            rs1_reg;
    logic [4:0]            rs2_reg;
    logic [4:0]            rd_reg;
    logic                  rd_wr_reg;
    logic                  err_unit_reg;
    logic                  err_retire_reg;

    logic [NB_INT_REG-1:0] pend;
    logic [NB_INT_REG-1:0] cnt_nz;
    logic [NB_INT_REG-1:0] err_hit;
    logic [31:0]           pend_ext;
    logic                  hazard;
    logic                  issue;
    logic                  accept;
    logic                  unit_ok;

    assign unit_ok = (i_unit != '0) && ((i_unit & (i_unit - NB_UNIT'(1))) == '0);

    // Registers beyond NB_INT_REG read as never pending.
    assign pend_ext = 32'(pend);
    // A non-zero count already covers the saturated (max) count, so the WAW
    // check alone guarantees the increment can never overflow.
    assign hazard   = pend_ext[rs1_reg] | pend_ext[rs2_reg] | (rd_wr_reg & pend_ext[rd_reg]);

    assign o_valid    = (full_reg && !hazard) ? unit_reg : '0;
    assign issue      = |(o_valid & o_ready);
    assign i_ready    = !full_reg || issue;
    assign accept     = i_valid && i_ready;
    assign o_instbus  = instbus_reg;
    assign busy       = full_reg || (|cnt_nz);
    assign err_unit   = err_unit_reg;
    assign err_retire = err_retire_reg;

    // Instructions with a bad unit select are swallowed: never stored, only flagged.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            full_reg     <= 1'b0;
            err_unit_reg <= 1'b0;
        end else begin
            err_unit_reg <= accept && !unit_ok;
            if (accept) begin
                full_reg <= unit_ok;
            end else if (issue) begin
                full_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (accept) begin
            instbus_reg <= i_instbus;
            unit_reg    <= i_unit;
            rs1_reg     <= i_rs1;
            rs2_reg     <= i_rs2;
            rd_reg      <= i_rd;
            rd_wr_reg   <= i_rd_wr;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_retire_reg <= 1'b0;
        end else if (|err_hit) begin
            err_retire_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB_INT_REG; gi++) begin : g_reg
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [CNT_W-1:0] cnt_eff;
            logic [SUM_W-1:0] nret;
            logic [SUM_W-1:0] sum;
            logic             inc;

            always_comb begin
                nret = '0;
                for (int k = 0; k < NB_UNIT; k++) begin
                    if (gi != 0 && ret_valid[k] && ret_rd[k*5 +: 5] == 5'(gi)) begin
                        nret = nret + SUM_W'(1);
                    end
                end
            end

            assign inc          = (gi != 0) && issue && rd_wr_reg && (rd_reg == 5'(gi));
            assign sum          = SUM_W'(cnt_reg) + SUM_W'(inc);
            assign err_hit[gi]  = sum < nret;
            assign cnt_next     = err_hit[gi] ? '0 : CNT_W'(sum - nret);
            assign cnt_nz[gi]   = cnt_reg != '0;

`ifdef FRISCV_SCB_RETIRE_FWD_EN
            assign cnt_eff = (SUM_W'(cnt_reg) > nret) ? CNT_W'(SUM_W'(cnt_reg) - nret) : '0;
`else
            assign cnt_eff = cnt_reg;
`endif
            assign pend[gi] = (gi != 0) && (cnt_eff != '0);

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

endmodule
